// File: rtl/wave_seq_pkg.sv
// Shared types and default widths for the triangle-wave sequencer.
package wave_seq_pkg;

    localparam int PRESC_W_DEF = 17;
    localparam int DWELL_W_DEF = 8;
    localparam int CYC_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RISE      = 3'd1,
        ST_DWELL_TOP = 3'd2,
        ST_FALL      = 3'd3,
        ST_DWELL_BOT = 3'd4,
        ST_DONE      = 3'd5
    } wave_state_t;

endpackage

// File: rtl/step_prescaler.sv
// Step divider: strobes tick every div+1 enabled clocks. Holds while disabled.
module step_prescaler #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == div);

    // Count enabled clocks, wrapping to 0 on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/wave_sequencer.sv
// Triangle-wave duty sequencer: ramp up, dwell, ramp down, dwell, repeated
// for a programmed number of cycles, with start/stop/done handshake.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int CYC_W   = CYC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PRESC_W-1:0] step_div,
    input  logic [7:0]         peak,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CYC_W-1:0]   n_cycles,
    output logic [7:0]         value,
    output logic               dir,
    output logic               busy,
    output logic               done
);

    wave_state_t        state, nxt;
    logic [PRESC_W-1:0] step_div_r;
    logic [7:0]         peak_r;
    logic [DWELL_W-1:0] dwell_r, dcnt, nxt_dcnt;
    logic [CYC_W-1:0]   n_cycles_r, cyc, nxt_cyc, cyc_inc;
    logic [7:0]         nxt_value, val_inc, val_dec;
    logic               stop_flag, stop_req, running, load, tick;

    assign running  = (state == ST_RISE) || (state == ST_DWELL_TOP) ||
                      (state == ST_FALL) || (state == ST_DWELL_BOT);
    // A stop sampled this cycle acts immediately, a remembered one keeps acting.
    assign stop_req = running && (stop || stop_flag);
    assign val_inc  = value + 8'd1;
    assign val_dec  = value - 8'd1;
    assign cyc_inc  = cyc + CYC_W'(1);

    step_prescaler #(.W(PRESC_W)) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (running),
        .clear  (load),
        .div    (step_div_r),
        .tick   (tick)
    );

    // Next-state, value and counter updates.
    always_comb begin
        nxt       = state;
        nxt_value = value;
        nxt_dcnt  = dcnt;
        nxt_cyc   = cyc;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    nxt_value = 8'd0;
                    nxt_cyc   = '0;
                    nxt       = (peak == 8'd0) ? ST_DONE : ST_RISE;
                end
            end
            ST_RISE: begin
                // Stopping at 0 has nothing to ramp down, so finish directly.
                if (stop_req) begin
                    nxt = (value == 8'd0) ? ST_DONE : ST_FALL;
                end else if (tick) begin
                    nxt_value = val_inc;
                    if (val_inc == peak_r) begin
                        nxt      = ST_DWELL_TOP;
                        nxt_dcnt = dwell_r;
                    end
                end
            end
            ST_DWELL_TOP: begin
                if (stop_req)              nxt = ST_FALL;
                else if (tick) begin
                    if (dcnt == '0)        nxt = ST_FALL;
                    else                   nxt_dcnt = dcnt - DWELL_W'(1);
                end
            end
            ST_FALL: begin
                if (tick) begin
                    nxt_value = val_dec;
                    if (val_dec == 8'd0) begin
                        nxt      = stop_req ? ST_DONE : ST_DWELL_BOT;
                        nxt_dcnt = dwell_r;
                    end
                end
            end
            ST_DWELL_BOT: begin
                if (stop_req) begin
                    nxt = ST_DONE;
                end else if (tick) begin
                    if (dcnt == '0) begin
                        nxt_cyc = cyc_inc;
                        nxt     = (n_cycles_r != '0 && cyc_inc == n_cycles_r) ? ST_DONE : ST_RISE;
                    end else begin
                        nxt_dcnt = dcnt - DWELL_W'(1);
                    end
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs (outputs follow the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            value <= 8'd0;
            dcnt  <= '0;
            cyc   <= '0;
            dir   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            value <= nxt_value;
            dcnt  <= nxt_dcnt;
            cyc   <= nxt_cyc;
            dir   <= (nxt == ST_RISE) || (nxt == ST_DWELL_TOP);
            busy  <= (nxt == ST_RISE) || (nxt == ST_DWELL_TOP) ||
                     (nxt == ST_FALL) || (nxt == ST_DWELL_BOT);
            done  <= (nxt == ST_DONE);
        end
    end

    // Configuration snapshot taken when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_div_r <= '0;
            peak_r     <= 8'd0;
            dwell_r    <= '0;
            n_cycles_r <= '0;
        end else if (load) begin
            step_div_r <= step_div;
            peak_r     <= peak;
            dwell_r    <= dwell;
            n_cycles_r <= n_cycles;
        end
    end

    // Pending stop: remembered while busy, forgotten once back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                stop_flag <= 1'b0;
        else if (state == ST_IDLE) stop_flag <= 1'b0;
        else if (running && stop)  stop_flag <= 1'b1;
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: every cycle is compared against a
// trajectory model that expands the configured profile into per-cycle values.
module tb_wave_sequencer;

    localparam int PW = 17;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] step_div = '0;
    logic [7:0]    peak = 8'd0;
    logic [DW-1:0] dwell = '0;
    logic [CW-1:0] n_cycles = '0;
    logic [7:0]    value;
    logic          dir, busy, done;

    wave_sequencer #(.PRESC_W(PW), .DWELL_W(DW), .CYC_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .step_div (step_div),
        .peak     (peak),
        .dwell    (dwell),
        .n_cycles (n_cycles),
        .value    (value),
        .dir      (dir),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    localparam int PH_RISE = 0, PH_TOP = 1, PH_FALL = 2, PH_BOT = 3, PH_DONE = 4;

    typedef struct {
        int v;
        bit d, b, dn;
        int ph;
        int pos;
    } exp_t;

    exp_t q[$];
    int   m_s, m_p, m_d, m_n, gen_cnt;
    bit   more, done_pushed;
    int   checks = 0, errors = 0;
    int   cyc_no = 0, last_done_cyc = -1, max_val = 0;
    int   s_value;
    bit   s_busy, s_done;

    function automatic void push_e(int v, bit d, bit b, bit dn, int ph, int pos);
        exp_t e;
        e.v = v; e.d = d; e.b = b; e.dn = dn; e.ph = ph; e.pos = pos;
        q.push_back(e);
    endfunction

    function automatic void push_done();
        push_e(0, 0, 0, 1, PH_DONE, 0);
    endfunction

    // One full up/dwell/down/dwell cycle, every step lasting m_s+1 clocks.
    function automatic void gen_cycle();
        for (int v = 0; v < m_p; v++)
            for (int k = 0; k <= m_s; k++) push_e(v, 1, 1, 0, PH_RISE, k);
        for (int j = 0; j <= m_d; j++)
            for (int k = 0; k <= m_s; k++) push_e(m_p, 1, 1, 0, PH_TOP, k);
        for (int v = m_p; v >= 1; v--)
            for (int k = 0; k <= m_s; k++) push_e(v, 0, 1, 0, PH_FALL, k);
        for (int j = 0; j <= m_d; j++)
            for (int k = 0; k <= m_s; k++) push_e(0, 0, 1, 0, PH_BOT, k);
        gen_cnt++;
    endfunction

    function automatic void refill();
        while (more && q.size() < 4000) begin
            gen_cycle();
            if (m_n != 0 && gen_cnt == m_n) more = 0;
        end
        if (!more && !done_pushed) begin
            push_done();
            done_pushed = 1;
        end
    endfunction

    // Ramp down from the value shown at step position pos, then finish.
    function automatic void fall_tail(int v0, int pos0);
        int v, pos;
        v = v0; pos = pos0;
        do begin
            if (pos == m_s) v--;
            pos = (pos == m_s) ? 0 : pos + 1;
            if (v != 0) push_e(v, 0, 1, 0, PH_FALL, pos);
        end while (v != 0);
        push_done();
    endfunction

    function automatic void model_reset();
        q.delete();
        more = 0;
        done_pushed = 1;
    endfunction

    function automatic void chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    // One clock: drive pulses, compare this cycle's outputs, advance the model.
    task automatic cyc(input bit st, input bit sp);
        exp_t e;
        bit   have;
        int   np;
        start = st;
        stop  = sp;
        @(negedge clk);
        have = (q.size() > 0);
        if (have) e = q[0];
        else begin
            e.v = 0; e.d = 0; e.b = 0; e.dn = 0; e.ph = PH_DONE; e.pos = 0;
        end
        checks++;
        if (value !== 8'(e.v) || dir !== e.d || busy !== e.b || done !== e.dn) begin
            errors++;
            if (errors < 30)
                $display("FAIL cycle %0d value/dir/busy/done: got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         cyc_no, value, dir, busy, done, e.v, e.d, e.b, e.dn);
        end
        s_value = int'(value); s_busy = busy; s_done = done;
        if (done) last_done_cyc = cyc_no;
        if (int'(value) > max_val) max_val = int'(value);

        if (!have) begin
            if (st) begin
                m_s = int'(step_div); m_p = int'(peak); m_d = int'(dwell); m_n = int'(n_cycles);
                gen_cnt = 0;
                if (m_p == 0) begin
                    more = 0; done_pushed = 1; push_done();
                end else begin
                    more = 1; done_pushed = 0; refill();
                end
            end
        end else begin
            void'(q.pop_front());
            if (sp && e.b) begin
                q.delete();
                more = 0;
                done_pushed = 1;
                if (e.ph == PH_BOT) push_done();
                else if (e.ph == PH_FALL) fall_tail(e.v, e.pos);
                else if (e.v == 0) push_done();
                else begin
                    np = (e.pos == m_s) ? 0 : e.pos + 1;
                    push_e(e.v, 0, 1, 0, PH_FALL, np);
                    fall_tail(e.v, np);
                end
            end else begin
                refill();
            end
        end
        @(posedge clk);
        #1;
        start = 0;
        stop  = 0;
        cyc_no++;
    endtask

    task automatic wait_done(input int t0, input string name);
        for (int i = 0; i < 4000; i++) begin
            if (last_done_cyc > t0) break;
            cyc(0, 0);
        end
        if (last_done_cyc <= t0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done expected done", name);
        end
    endtask

    typedef struct {
        int sd, p, d, n;
        int lat, pk;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t0;

        vecs[0] = '{sd: 0, p: 3,   d: 0, n: 1, lat: 9,   pk: 3};
        vecs[1] = '{sd: 3, p: 2,   d: 1, n: 2, lat: 65,  pk: 2};
        vecs[2] = '{sd: 0, p: 0,   d: 2, n: 1, lat: 1,   pk: 0};
        vecs[3] = '{sd: 1, p: 1,   d: 0, n: 3, lat: 25,  pk: 1};
        vecs[4] = '{sd: 2, p: 4,   d: 2, n: 1, lat: 43,  pk: 4};
        vecs[5] = '{sd: 0, p: 255, d: 0, n: 1, lat: 513, pk: 255};
        vecs[6] = '{sd: 0, p: 5,   d: 3, n: 2, lat: 37,  pk: 5};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_value", int'(value), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_dir", int'(dir), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 0);

        // Basic cycle spelled out value by value.
        begin
            int exp_v [9];
            exp_v = '{0, 1, 2, 3, 3, 2, 1, 0, 0};
            step_div = '0; peak = 8'd3; dwell = '0; n_cycles = 8'd1;
            cyc(1, 0);
            for (int i = 0; i < 9; i++) begin
                cyc(0, 0);
                chk($sformatf("basic_value_%0d", i), s_value, exp_v[i]);
                chk($sformatf("basic_done_%0d", i), int'(s_done), (i == 8) ? 1 : 0);
            end
            cyc(0, 0);
            chk("basic_busy_after", int'(s_busy), 0);
        end

        // Table of configurations: latency from start sample to done, and peak.
        for (int i = 0; i < 7; i++) begin
            step_div = PW'(vecs[i].sd); peak = 8'(vecs[i].p);
            dwell = DW'(vecs[i].d); n_cycles = CW'(vecs[i].n);
            max_val = 0;
            t0 = cyc_no;
            cyc(1, 0);
            wait_done(t0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_latency", i), last_done_cyc - t0, vecs[i].lat);
            chk($sformatf("vec%0d_peak", i), max_val, vecs[i].pk);
            cyc(0, 0);
        end

        // Graceful stop while rising at 6: ramps down with no dwell.
        step_div = '0; peak = 8'd10; dwell = 8'd2; n_cycles = '0;
        max_val = 0;
        t0 = cyc_no;
        cyc(1, 0);
        repeat (6) cyc(0, 0);
        cyc(0, 1);
        chk("stop_at_value", s_value, 6);
        wait_done(t0, "stop");
        chk("stop_latency", last_done_cyc - t0, 14);
        chk("stop_peak", max_val, 6);
        cyc(0, 0);

        // Start while busy plus config change: running sequence is unaffected.
        step_div = PW'(1); peak = 8'd3; dwell = '0; n_cycles = 8'd2;
        max_val = 0;
        t0 = cyc_no;
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        peak = 8'd9; step_div = '0; n_cycles = 8'd1;
        cyc(1, 0);
        wait_done(t0, "isolation");
        chk("isolation_latency", last_done_cyc - t0, 33);
        chk("isolation_peak", max_val, 3);

        // Stop in IDLE does nothing.
        cyc(0, 1);
        cyc(0, 0);
        chk("idle_stop_busy", int'(s_busy), 0);

        // Asynchronous reset mid-ramp, between clock edges.
        step_div = '0; peak = 8'd10; dwell = '0; n_cycles = '0;
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        chk("pre_reset_value", int'(value), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_value", int'(value), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step_div = '0; peak = 8'd3; dwell = '0; n_cycles = 8'd1;
        max_val = 0;
        t0 = cyc_no;
        cyc(1, 0);
        wait_done(t0, "after_reset");
        chk("after_reset_latency", last_done_cyc - t0, 9);

        // Random traffic against the trajectory model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(7) == 0) begin
                step_div = PW'($urandom_range(3));
                peak     = 8'($urandom_range(12));
                dwell    = DW'($urandom_range(3));
                n_cycles = CW'($urandom_range(3));
            end
            cyc($urandom_range(9) == 0, $urandom_range(39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
